dm_arbiter: RTL and testbench

- Two-master arbiter for the shared word-addressed data memory (byte-enable write, combinational read).
- Master C is the CPU M-stage data port; master D is a DMA/debug port.
- CPU has priority; a starvation counter and bounded DMA lock bursts guarantee progress for both masters.
- Sits between the `mips` core data port and the data memory, owning the memory's address, write-data and byteen lines.

---
 rtl/dm_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dm_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-master (CPU / DMA) arbiter in front of the word-addressed data memory.
// CPU has priority, bounded by a starvation counter and capped DMA lock bursts.

module dm_rd_port (
   input  logic        clk,
   input  logic        reset,
   input  logic        fire,
   input  logic [31:0] data,
   output logic        rvalid,
   output logic [31:0] rdata
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= fire;
         if (fire) rdata <= data;
      end
   end

endmodule

module dm_arbiter #(
   parameter int MAX_WAIT    = 4,
   parameter int BURST_MAX   = 8,
   parameter int DEPTH_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        c_req,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   input  logic [3:0]  c_byteen,
   output logic        c_gnt,
   output logic        c_rvalid,
   output logic [31:0] c_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_byteen,
   input  logic        d_lock,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byteen,
   input  logic [31:0] mem_rdata,
   output logic        err,
   output logic [1:0]  owner
);

   localparam int          NM        = 2;   // index 0 = CPU, 1 = DMA
   localparam logic [3:0]  WAIT_LIM  = 4'(MAX_WAIT);
   localparam logic [7:0]  BURST_LIM = 8'(BURST_MAX);
   localparam logic [31:0] DEPTH     = 32'(DEPTH_WORDS);

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  byteen;
   } dm_req_t;

   typedef enum logic {NORM, BURST} state_t;

   state_t           state, state_nxt;
   logic [3:0]       wait_cnt, wait_nxt;
   logic [7:0]       burst_cnt, burst_nxt;
   dm_req_t [NM-1:0] rq;
   dm_req_t          g;
   logic [NM-1:0]    gnt;
   logic [NM-1:0]    rd_fire;
   logic [NM-1:0]    rvalid;
   logic [NM-1:0][31:0] rdata_q;
   logic             oor;
   logic [31:0]      rd_word;

   assign rq[0] = {c_req, c_addr, c_wdata, c_byteen};
   assign rq[1] = {d_req, d_addr, d_wdata, d_byteen};

   // Grants are gated by reset so the memory side goes idle the instant reset asserts.
   always_comb begin
      gnt = '0;
      if (reset) begin
         if (state == BURST)
            gnt[1] = rq[1].req;
         else if (rq[1].req && (wait_cnt == WAIT_LIM || !rq[0].req))
            gnt[1] = 1'b1;
         else
            gnt[0] = rq[0].req;
      end
   end

   assign c_gnt = gnt[0];
   assign d_gnt = gnt[1];

   always_comb begin
      g = '0;
      if (gnt[1])      g = rq[1];
      else if (gnt[0]) g = rq[0];
   end

   assign oor        = g.req && ((g.addr >> 2) >= DEPTH);
   assign mem_addr   = g.addr & 32'hFFFF_FFFC;
   assign mem_wdata  = g.wdata;
   assign mem_byteen = oor ? 4'h0 : g.byteen;
   assign rd_word    = oor ? 32'h0 : mem_rdata;

   genvar i;
   for (i = 0; i < NM; i++) begin : g_rd
      assign rd_fire[i] = gnt[i] && (rq[i].byteen == 4'h0);
      dm_rd_port u_rd (
         .clk    (clk),
         .reset  (reset),
         .fire   (rd_fire[i]),
         .data   (rd_word),
         .rvalid (rvalid[i]),
         .rdata  (rdata_q[i])
      );
   end

   assign c_rvalid = rvalid[0];
   assign c_rdata  = rdata_q[0];
   assign d_rvalid = rvalid[1];
   assign d_rdata  = rdata_q[1];

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      burst_nxt = burst_cnt;
      case (state)
         NORM: begin
            if (gnt[1] || !d_req)
               wait_nxt = '0;
            else if (wait_cnt != WAIT_LIM)
               wait_nxt = wait_cnt + 4'd1;
            if (gnt[1] && d_lock && (BURST_MAX > 1)) begin
               state_nxt = BURST;
               burst_nxt = 8'd1;
            end
         end
         BURST: begin
            // Leaving with wait_cnt cleared lets the CPU win right after a forced release.
            if (!d_req || !d_lock || (burst_cnt + 8'd1 == BURST_LIM)) begin
               state_nxt = NORM;
               wait_nxt  = '0;
               burst_nxt = '0;
            end else begin
               burst_nxt = burst_cnt + 8'd1;
            end
         end
         default: state_nxt = NORM;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= NORM;
         wait_cnt  <= '0;
         burst_cnt <= '0;
         err       <= 1'b0;
         owner     <= 2'b00;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_nxt;
         burst_cnt <= burst_nxt;
         err       <= oor;
         owner     <= {gnt[1], gnt[0]};
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios with literal expectations plus random traffic
// checked every cycle against a transaction-level model with its own reference memory.

module tb_dm_arbiter;

   localparam int MAX_WAIT  = 4;
   localparam int BURST_MAX = 8;
   localparam int DEPTH     = 4096;

   logic        clk = 1'b0, reset = 1'b0;
   logic        c_req, c_gnt, c_rvalid, d_req, d_gnt, d_rvalid, d_lock, err;
   logic [31:0] c_addr, c_wdata, c_rdata, d_addr, d_wdata, d_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  c_byteen, d_byteen, mem_byteen;
   logic [1:0]  owner;

   dm_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX), .DEPTH_WORDS(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_byteen(c_byteen),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteen(d_byteen),
      .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
      .mem_rdata(mem_rdata), .err(err), .owner(owner)
   );

   always #5 clk = ~clk;

   // Environment memory seen by the DUT; out-of-range reads return junk the DUT must mask.
   logic [31:0] env_mem [0:DEPTH-1];
   assign mem_rdata = ((mem_addr >> 2) < DEPTH) ? env_mem[mem_addr[13:2]] : 32'hBADC0FFE;
   always @(posedge clk)
      if ((mem_addr >> 2) < DEPTH)
         for (int b = 0; b < 4; b++)
            if (mem_byteen[b]) env_mem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

   int total = 0, bad = 0;

   // Reference model state
   logic [31:0] ref_mem [0:DEPTH-1];
   bit          m_burst;
   int          m_beats, m_denied;
   logic [1:0]  e_owner;
   logic        e_err, e_crv, e_drv;
   logic [31:0] e_crd, e_drd;

   logic        obs_c, obs_d, obs_err, obs_crv, obs_drv;
   logic [3:0]  obs_be;
   logic [1:0]  obs_owner;
   logic [31:0] obs_crd, obs_drd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_burst = 0; m_beats = 0; m_denied = 0;
      e_owner = 2'b00; e_err = 0; e_crv = 0; e_drv = 0; e_crd = '0; e_drd = '0;
   endtask

   // One cycle: sample at the falling edge, check against the model, advance the model.
   task automatic tick();
      bit gc, gd, oor, rd;
      logic [31:0] ga, gw, wa;
      logic [3:0]  gb;
      #4;
      obs_c = c_gnt; obs_d = d_gnt; obs_be = mem_byteen; obs_owner = owner; obs_err = err;
      obs_crv = c_rvalid; obs_drv = d_rvalid; obs_crd = c_rdata; obs_drd = d_rdata;
      if (reset) begin
         gc = 0; gd = 0;
         if (m_burst) gd = d_req;
         else if (d_req && (m_denied >= MAX_WAIT || !c_req)) gd = 1;
         else gc = c_req;
         ga = gd ? d_addr : gc ? c_addr : '0;
         gw = gd ? d_wdata : gc ? c_wdata : '0;
         gb = gd ? d_byteen : gc ? c_byteen : '0;
         wa = ga >> 2;
         oor = (gc || gd) && (wa >= DEPTH);
         rd = (gc || gd) && (gb == 4'h0);
         chk("c_gnt", c_gnt, gc);
         chk("d_gnt", d_gnt, gd);
         chk("mem_addr", mem_addr, {ga[31:2], 2'b00});
         chk("mem_wdata", mem_wdata, gw);
         chk("mem_byteen", mem_byteen, oor ? 4'h0 : gb);
         chk("owner", owner, e_owner);
         chk("err", err, e_err);
         chk("c_rvalid", c_rvalid, e_crv);
         chk("d_rvalid", d_rvalid, e_drv);
         chk("c_rdata", c_rdata, e_crd);
         chk("d_rdata", d_rdata, e_drd);
         // registered expectations for the next cycle
         e_owner = gd ? 2'b10 : gc ? 2'b01 : 2'b00;
         e_err = oor;
         e_crv = rd && gc;
         e_drv = rd && gd;
         if (rd && gc) e_crd = oor ? '0 : ref_mem[wa[11:0]];
         if (rd && gd) e_drd = oor ? '0 : ref_mem[wa[11:0]];
         if ((gc || gd) && !oor)
            for (int b = 0; b < 4; b++)
               if (gb[b]) ref_mem[wa[11:0]][8*b +: 8] = gw[8*b +: 8];
         if (m_burst) begin
            if (!d_req) begin
               m_burst = 0; m_beats = 0; m_denied = 0;
            end else begin
               m_beats++;
               if (!d_lock || m_beats == BURST_MAX) begin
                  m_burst = 0; m_beats = 0; m_denied = 0;
               end
            end
         end else if (gd) begin
            m_denied = 0;
            if (d_lock && BURST_MAX > 1) begin m_burst = 1; m_beats = 1; end
         end else if (d_req) begin
            m_denied = (m_denied + 1 > MAX_WAIT) ? MAX_WAIT : m_denied + 1;
         end else begin
            m_denied = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      c_req = 0; c_addr = '0; c_wdata = '0; c_byteen = '0;
      d_req = 0; d_addr = '0; d_wdata = '0; d_byteen = '0; d_lock = 0;
   endtask

   function automatic logic [31:0] raddr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 32'h4000 + 32'($urandom_range(0, 63));
      if (r == 1) return 32'h8000_0000 | 32'($urandom);
      return 32'($urandom_range(0, 127));
   endfunction

   initial begin
      for (int w = 0; w < DEPTH; w++) begin env_mem[w] = '0; ref_mem[w] = '0; end
      idle_inputs();
      model_reset();
      // Reset: requests present but nothing may be granted
      c_req = 1; d_req = 1; c_addr = 32'h40; c_byteen = 4'hF; c_wdata = 32'h1111_2222;
      #3;
      chk("rst_c_gnt", c_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_byteen", mem_byteen, 0);
      chk("rst_owner", owner, 0);
      chk("rst_err", err, 0);
      chk("rst_rvalid", {c_rvalid, d_rvalid}, 0);
      chk("rst_rdata", c_rdata | d_rdata, 0);
      @(posedge clk); @(posedge clk); #1;
      idle_inputs();
      reset = 1;

      // CPU write then read of 0x10
      c_req = 1; c_addr = 32'h10; c_byteen = 4'hF; c_wdata = 32'hDEADBEEF;
      tick();
      chk("conly_wr_gnt", obs_c, 1);
      chk("conly_wr_be", obs_be, 4'hF);
      c_byteen = 4'h0;
      tick();
      chk("conly_rd_gnt", obs_c, 1);
      c_req = 0;
      tick();
      chk("conly_rvalid", obs_crv, 1);
      chk("conly_rdata", obs_crd, 32'hDEADBEEF);

      // Starvation: D wins on the 5th contended cycle, then C again
      c_req = 1; c_byteen = 4'h0; d_req = 1; d_addr = 32'h10; d_byteen = 4'h0; d_lock = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("starve_d", obs_d, 32'(i == 4));
         chk("starve_c", obs_c, 32'(i != 4));
      end
      idle_inputs(); tick();

      // Locked burst: 8 D beats once D wins, then C
      c_req = 1; d_req = 1; d_lock = 1; d_addr = 32'h10;
      for (int i = 0; i < 14; i++) begin
         tick();
         chk("burst_d", obs_d, 32'(i >= 4 && i <= 11));
         chk("burst_c", obs_c, 32'(i < 4 || i >= 12));
         if (i >= 5) chk("burst_owner", obs_owner, (i <= 12) ? 32'd2 : 32'd1);
      end
      idle_inputs(); tick();

      // Early exit: lock drops on beat 3
      d_req = 1; d_lock = 1; d_addr = 32'h10;
      tick(); chk("early_b1", obs_d, 1);
      c_req = 1;
      tick(); chk("early_b2", obs_d, 1);
      d_lock = 0;
      tick(); chk("early_b3", obs_d, 1);
      tick(); chk("early_c", obs_c, 1);
      idle_inputs(); tick();

      // Out of range write then read
      d_req = 1; d_addr = 32'h4000; d_byteen = 4'hF; d_wdata = 32'h1234_5678;
      tick();
      chk("oor_gnt", obs_d, 1);
      chk("oor_be", obs_be, 0);
      d_byteen = 4'h0;
      tick();
      chk("oor_err", obs_err, 1);
      d_req = 0;
      tick();
      chk("oor_rvalid", obs_drv, 1);
      chk("oor_rdata", obs_drd, 0);
      chk("oor_err2", obs_err, 1);
      idle_inputs(); tick();

      // Asynchronous reset during beat 2 of a read burst
      d_req = 1; d_lock = 1; d_addr = 32'h10; d_byteen = 4'h0;
      tick();
      #2 reset = 0;
      #1;
      chk("arst_gnt", {c_gnt, d_gnt}, 0);
      chk("arst_rvalid", d_rvalid, 0);
      chk("arst_err", err, 0);
      chk("arst_owner", owner, 0);
      chk("arst_be", mem_byteen, 0);
      chk("arst_rdata", d_rdata, 0);
      @(posedge clk); #1;
      reset = 1;
      model_reset();
      c_req = 1; d_req = 1; d_lock = 0;
      tick();
      chk("arst_c_first", obs_c, 1);
      chk("arst_d_not", obs_d, 0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         c_req = ($urandom_range(0, 9) < 6);
         d_req = ($urandom_range(0, 9) < 5);
         d_lock = $urandom_range(0, 1);
         c_addr = raddr(); d_addr = raddr();
         c_wdata = $urandom; d_wdata = $urandom;
         c_byteen = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
         d_byteen = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
         tick();
      end
      idle_inputs(); tick();
      for (int w = 0; w < 32; w++) chk("mem_final", env_mem[w], ref_mem[w]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
